sync_fifo_lvl: RTL

Single-clock, parametrised FIFO for the video-DDR path, used where producer and consumer share a clock (pixel repacking ahead of the DDR write port, line buffers in the stitch datapath). It adds four things to the existing dual-clock FIFO: programmable almost-full/almost-empty thresholds, an exact fill-level output, a synchronous flush, and a selectable first-word-fall-through or registered-read mode. Optional sticky overflow/underflow error flags are compiled in by macro.

---
 rtl/sync_fifo_pkg.sv | 28 ++
 rtl/sync_fifo_ram.sv | 35 +++
 rtl/sync_fifo_lvl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for sync_fifo_lvl and its RAM.
// Provides the FALLTHROUGH mode strings, the level-counter width helper,
// the RAM depth helper and the default almost-full/almost-empty thresholds.
package sync_fifo_pkg;

  // Values accepted by the FALLTHROUGH parameter.
  localparam string MODE_FWFT = "TRUE";
  localparam string MODE_REG  = "FALSE";

  // Number of words addressable with asize address bits.
  function automatic int depth(input int asize);
    return 1 << asize;
  endfunction

  // Level must represent 0..2^asize inclusive, so it needs one extra bit.
  function automatic int lvl_width(input int asize);
    return asize + 1;
  endfunction

  function automatic int afull_default(input int asize);
    return depth(asize) - 4;
  endfunction

  function automatic int aempty_default();
    return 4;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port RAM, DSIZE x 2^ASIZE.
// Latency: write lands at the clock edge; read data is registered (1 cycle).
// Backpressure: none; the read register holds its value while re is low.
// Ports: clk; we/waddr/wdata write port; re/raddr read port; q read data.
// A read and a write to the same address on one edge return the old word.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int ASIZE = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] q
);

  logic [DSIZE-1:0] mem [0:depth(ASIZE)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock FIFO with exact level, programmable almost
// flags, synchronous flush and FWFT or registered-read output.
// Latency: write-to-read 1 cycle (FWFT); registered mode data 1 cycle after rinc.
// Backpressure: writes refused while wfull, reads refused while rempty.
// Ports: clk, rst (sync, active-high), flush; winc/wdata/wfull/awfull write
// side; rinc/rdata/rempty/arempty read side; level; ovf/udf sticky errors.
// Macro SYNC_FIFO_ERR_EN compiles in the ovf/udf logic; otherwise both are 0.
module sync_fifo_lvl
  import sync_fifo_pkg::*;
#(
  parameter int    DSIZE       = 16,
  parameter int    ASIZE       = 9,
  parameter string FALLTHROUGH = MODE_FWFT,
  parameter int    AFULL_LVL   = afull_default(ASIZE),
  parameter int    AEMPTY_LVL  = aempty_default()
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  output logic [ASIZE:0]   level,
  output logic             ovf,
  output logic             udf
);

  localparam int              LW         = lvl_width(ASIZE);
  localparam bit              FWFT       = (FALLTHROUGH != MODE_REG);
  localparam logic [LW-1:0]   DEPTH_L    = LW'(depth(ASIZE));
  localparam logic [LW-1:0]   AFULL_L    = LW'(AFULL_LVL);
  localparam logic [LW-1:0]   AEMPTY_L   = LW'(AEMPTY_LVL);
  localparam logic            AWFULL_RST = (AFULL_LVL == 0);

  logic             wr_acc;
  logic             rd_acc;
  logic [LW-1:0]    level_rd;
  logic [LW-1:0]    level_nxt;
  logic [ASIZE-1:0] wptr;
  logic [ASIZE-1:0] rptr;
  logic [ASIZE-1:0] rptr_nxt;
  logic             ram_we;
  logic             ram_re;
  logic [ASIZE-1:0] ram_raddr;
  logic [DSIZE-1:0] ram_q;
  logic             byp_load;
  logic             byp_sel;
  logic [DSIZE-1:0] byp_dat;

  always_comb begin
    wr_acc    = winc && !wfull;
    rd_acc    = rinc && !rempty;
    level_rd  = level - LW'(rd_acc);
    level_nxt = level_rd + LW'(wr_acc);
    rptr_nxt  = rptr + ASIZE'(rd_acc);
    ram_we    = wr_acc && !rst && !flush;
    ram_re    = 1'b0;
    ram_raddr = rptr;
    byp_load  = 1'b0;
    if (FWFT) begin
      // Keep the RAM read register tracking the head after this edge. While
      // the FIFO stays empty it holds, so rdata does not wander.
      ram_re    = (level_nxt != '0);
      ram_raddr = rptr_nxt;
      // A word written into a FIFO that is empty after this edge's read is
      // the new head, but the RAM read register cannot see it until the next
      // edge, so it is steered through the bypass register instead.
      byp_load  = wr_acc && (level_rd == '0);
    end else begin
      ram_re    = rd_acc;
      ram_raddr = rptr;
    end
  end

  sync_fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .q     (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      level   <= '0;
      wptr    <= '0;
      rptr    <= '0;
      wfull   <= 1'b0;
      awfull  <= AWFULL_RST;
      rempty  <= 1'b1;
      arempty <= 1'b1;
      // Selecting a zeroed bypass register gives rdata = 0 without needing
      // a reset on the RAM read register.
      byp_sel <= 1'b1;
      byp_dat <= '0;
    end else begin
      level   <= level_nxt;
      wptr    <= wptr + ASIZE'(wr_acc);
      rptr    <= rptr_nxt;
      wfull   <= (level_nxt == DEPTH_L);
      awfull  <= (level_nxt >= AFULL_L);
      rempty  <= (level_nxt == '0);
      arempty <= (level_nxt <= AEMPTY_L);
      if (FWFT) begin
        if (byp_load) begin
          byp_sel <= 1'b1;
          byp_dat <= wdata;
        end else if (level_nxt != '0) begin
          byp_sel <= 1'b0;
        end
      end else if (rd_acc) begin
        byp_sel <= 1'b0;
      end
    end
  end

  assign rdata = byp_sel ? byp_dat : ram_q;

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (winc && wfull) begin
        ovf <= 1'b1;
      end
      if (rinc && rempty) begin
        udf <= 1'b1;
      end
    end
  end
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule
